// File: rtl/pcie_dll_replay.sv
// PCIe data-link-layer transmit stage: sequence numbering, replay buffer, ACK/NAK
// consumption, replay timer and link-retrain escalation after repeated replays.
module pcie_dll_replay #(
    parameter int DATA_W         = 1024,
    parameter int REPLAY_DEPTH   = 4,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tlp_data_i,
    input  logic              tlp_valid_i,
    output logic              tlp_ready_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [11:0]       tx_seq_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [31:0]       dllp_i,
    input  logic              dllp_valid_i,
    output logic              replay_active_o,
    output logic              link_retrain_o,
    output logic              dllp_err_o
);
    localparam int IDX_W = $clog2(REPLAY_DEPTH);
    localparam int TMR_W = $clog2(REPLAY_TIMEOUT);

    localparam logic [7:0]       TYPE_ACK = 8'h00;
    localparam logic [7:0]       TYPE_NAK = 8'h10;
    localparam logic [11:0]      DEPTH    = 12'(REPLAY_DEPTH);
    localparam logic [TMR_W-1:0] TMR_ARM  = TMR_W'(REPLAY_TIMEOUT - 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REPLAY_TIMEOUT - 1);

    typedef enum logic {NORMAL = 1'b0, REPLAY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              live;
    logic [11:0]       next_seq, snd_seq, acked_seq, replay_end;
    logic [11:0]       next_seq_nxt, snd_seq_nxt, acked_seq_nxt, replay_end_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [1:0]        replay_num, replay_num_nxt;
    logic              replay_pend, replay_pend_nxt;
    logic              retrain_nxt, err_nxt;
    logic [DATA_W-1:0] buffer [REPLAY_DEPTH];

    logic [11:0] outstanding, sent_cnt, dllp_seq, dllp_ofs;
    logic        accept, tx_fire, tx_stall, replay_start;
    logic        is_ack, is_nak, in_window, ack_ok, nak_ok, dup_ack;
    logic        dllp_unused;

    assign dllp_unused = ^dllp_i[23:12];

    // Modulo-4096 distances from the last acknowledged sequence number.
    assign outstanding = next_seq - acked_seq - 12'd1;
    assign sent_cnt    = snd_seq - acked_seq - 12'd1;
    assign dllp_seq    = dllp_i[11:0];
    assign dllp_ofs    = dllp_seq - acked_seq;

    assign is_ack    = dllp_valid_i && (dllp_i[31:24] == TYPE_ACK);
    assign is_nak    = dllp_valid_i && (dllp_i[31:24] == TYPE_NAK);
    assign in_window = (dllp_ofs != 12'd0) && (dllp_ofs <= sent_cnt);
    assign ack_ok    = is_ack && in_window;
    assign dup_ack   = is_ack && (dllp_ofs == 12'd0);
    assign nak_ok    = is_nak && (in_window || dllp_ofs == 12'd0);

    assign tlp_ready_o     = live && (state == NORMAL) && (outstanding < DEPTH);
    assign accept          = tlp_valid_i && tlp_ready_o;
    assign tx_valid_o      = (snd_seq != next_seq);
    assign tx_fire         = tx_valid_o && tx_ready_i;
    assign tx_stall        = tx_valid_o && !tx_ready_i;
    assign tx_seq_o        = snd_seq;
    // Masked so that the link never sees stale buffer contents while idle or in reset.
    assign tx_data_o       = tx_valid_o ? buffer[snd_seq[IDX_W-1:0]] : '0;
    assign replay_active_o = (state == REPLAY);
    assign replay_start    = replay_pend && !tx_stall;

    // NOTE: every variable is given its hold value first so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        next_seq_nxt    = next_seq;
        snd_seq_nxt     = snd_seq;
        acked_seq_nxt   = acked_seq;
        replay_end_nxt  = replay_end;
        timer_nxt       = timer;
        replay_num_nxt  = replay_num;
        replay_pend_nxt = replay_pend;
        retrain_nxt     = 1'b0;
        err_nxt         = 1'b0;

        if (accept)  next_seq_nxt = next_seq + 12'd1;
        if (tx_fire) snd_seq_nxt  = snd_seq + 12'd1;

        if (ack_ok) begin
            acked_seq_nxt  = dllp_seq;
            replay_num_nxt = 2'd0;
        end else if (nak_ok) begin
            acked_seq_nxt   = dllp_seq;
            replay_pend_nxt = 1'b1;
        end else if (dllp_valid_i && !dup_ack) begin
            err_nxt = 1'b1;
        end

        // Progress-making ACK clears the timer, so it also suppresses a same-cycle expiry.
        if (ack_ok || outstanding == 12'd0) begin
            timer_nxt = '0;
        end else if (state == NORMAL && timer != TMR_LAST) begin
            timer_nxt = timer + TMR_W'(1);
            if (timer == TMR_ARM) replay_pend_nxt = 1'b1;
        end

        if (replay_start) begin
            snd_seq_nxt     = acked_seq_nxt + 12'd1;
            replay_end_nxt  = next_seq_nxt;
            timer_nxt       = '0;
            state_nxt       = REPLAY;
            replay_pend_nxt = 1'b0;
            if (replay_num_nxt == 2'd3) begin
                replay_num_nxt = 2'd0;
                retrain_nxt    = 1'b1;
            end else begin
                replay_num_nxt = replay_num_nxt + 2'd1;
            end
        end else if (state == REPLAY) begin
            if (outstanding == 12'd0 || (tx_fire && snd_seq_nxt == replay_end))
                state_nxt = NORMAL;
        end
    end

    // NOTE: the replay buffer has no reset; the sequence counters alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (accept) buffer[next_seq[IDX_W-1:0]] <= tlp_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= NORMAL;
            live           <= 1'b0;
            next_seq       <= 12'd0;
            snd_seq        <= 12'd0;
            acked_seq      <= 12'hFFF;
            replay_end     <= 12'd0;
            timer          <= '0;
            replay_num     <= 2'd0;
            replay_pend    <= 1'b0;
            link_retrain_o <= 1'b0;
            dllp_err_o     <= 1'b0;
        end else begin
            state          <= state_nxt;
            live           <= 1'b1;
            next_seq       <= next_seq_nxt;
            snd_seq        <= snd_seq_nxt;
            acked_seq      <= acked_seq_nxt;
            replay_end     <= replay_end_nxt;
            timer          <= timer_nxt;
            replay_num     <= replay_num_nxt;
            replay_pend    <= replay_pend_nxt;
            link_retrain_o <= retrain_nxt;
            dllp_err_o     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pcie_dll_replay.sv
// Directed self-checking bench for pcie_dll_replay (32-bit data, depth 4, timeout 16).
module tb_pcie_dll_replay;
    localparam int DATA_W = 32;
    localparam logic [7:0] ACK = 8'h00;
    localparam logic [7:0] NAK = 8'h10;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] tlp_data;
    logic              tlp_valid;
    logic              tlp_ready;
    logic [DATA_W-1:0] tx_data;
    logic [11:0]       tx_seq;
    logic              tx_valid;
    logic              tx_ready;
    logic [31:0]       dllp;
    logic              dllp_valid;
    logic              replay_active;
    logic              link_retrain;
    logic              dllp_err;

    int checks = 0;
    int errors = 0;

    pcie_dll_replay #(
        .DATA_W        (DATA_W),
        .REPLAY_DEPTH  (4),
        .REPLAY_TIMEOUT(16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tlp_data_i     (tlp_data),
        .tlp_valid_i    (tlp_valid),
        .tlp_ready_o    (tlp_ready),
        .tx_data_o      (tx_data),
        .tx_seq_o       (tx_seq),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .dllp_i         (dllp),
        .dllp_valid_i   (dllp_valid),
        .replay_active_o(replay_active),
        .link_retrain_o (link_retrain),
        .dllp_err_o     (dllp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] pat(input int base, input int k);
        return DATA_W'(base + k);
    endfunction

    // Leaves the bench on a falling edge with reset released and the stage ready.
    task automatic do_reset();
        tlp_valid  = 1'b0;
        tlp_data   = '0;
        tx_ready   = 1'b1;
        dllp       = '0;
        dllp_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives a one-cycle DLLP; returns on the falling edge after it was consumed.
    task automatic send_dllp(input logic [7:0] typ, input logic [11:0] seq);
        dllp       = {typ, 12'h000, seq};
        dllp_valid = 1'b1;
        @(negedge clk);
        dllp_valid = 1'b0;
    endtask

    task automatic test_reset();
        tlp_valid = 1'b0; tx_ready = 1'b1; dllp_valid = 1'b0; dllp = '0; tlp_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({tlp_ready, tx_valid, replay_active, link_retrain, dllp_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {tlp_ready, tx_valid, replay_active, link_retrain, dllp_err}); end
        checks++; if (tx_seq !== 12'd0 || tx_data !== '0) begin
            errors++; $display("FAIL reset_tx got seq %0d data %h exp 0/0", tx_seq, tx_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tlp_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release got ready %b valid %b exp 1/0", tlp_ready, tx_valid); end
    endtask

    // T1: three TLPs appear one cycle after accept; ACK 2 empties the buffer and stops the timer.
    task automatic test_basic();
        int seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tlp_valid = 1'b1; tlp_data = pat(32'hA000_0000, i);
            @(negedge clk);
            checks++; if (tx_valid !== 1'b1 || tx_seq !== 12'(i) || tx_data !== pat(32'hA000_0000, i)) begin
                errors++; $display("FAIL basic_send%0d got v%b seq %0d data %h exp v1 seq %0d data %h",
                                   i, tx_valid, tx_seq, tx_data, i, pat(32'hA000_0000, i)); end
        end
        tlp_valid = 1'b0;
        @(negedge clk);
        send_dllp(ACK, 12'd2);
        checks++; if (dllp_err !== 1'b0 || tlp_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ack got err %b ready %b exp 0/1", dllp_err, tlp_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (replay_active || tx_valid) seen++;
        end
        checks++; if (seen !== 0) begin
            errors++; $display("FAIL basic_idle got %0d busy cycles exp 0", seen); end
    endtask

    // T2: four accepts fill the buffer; ACK 1 frees exactly two slots.
    task automatic test_depth();
        int n;
        do_reset();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tlp_valid = 1'b1; tlp_data = pat(32'hB000_0000, i);
            if (tlp_ready) n++;
            @(negedge clk);
        end
        checks++; if (n !== 4) begin
            errors++; $display("FAIL depth_fill got %0d accepts exp 4", n); end
        checks++; if (tlp_ready !== 1'b0) begin
            errors++; $display("FAIL depth_full got ready %b exp 0", tlp_ready); end
        send_dllp(ACK, 12'd1);
        checks++; if (tlp_ready !== 1'b1) begin
            errors++; $display("FAIL depth_after_ack got ready %b exp 1", tlp_ready); end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tlp_data = pat(32'hB000_0010, i);
            if (tlp_ready) n++;
            @(negedge clk);
        end
        tlp_valid = 1'b0;
        checks++; if (n !== 2) begin
            errors++; $display("FAIL depth_refill got %0d accepts exp 2", n); end
    endtask

    // T3: NAK 0 after seq 0..3 were sent replays 1,2,3 with their original data.
    task automatic test_nak();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tlp_valid = 1'b1; tlp_data = pat(32'hD000_0000, i);
            @(negedge clk);
        end
        tlp_valid = 1'b0;
        repeat (2) @(negedge clk);
        send_dllp(NAK, 12'd0);
        for (int w = 0; w < 4 && !replay_active; w++) @(negedge clk);
        checks++; if (replay_active !== 1'b1) begin
            errors++; $display("FAIL nak_replay got active %b exp 1", replay_active); end
        for (int k = 1; k < 4; k++) begin
            checks++; if (tx_valid !== 1'b1 || tx_seq !== 12'(k) || tx_data !== pat(32'hD000_0000, k) || tlp_ready !== 1'b0) begin
                errors++; $display("FAIL nak_resend%0d got v%b seq %0d data %h ready %b exp v1 seq %0d data %h ready 0",
                                   k, tx_valid, tx_seq, tx_data, tlp_ready, k, pat(32'hD000_0000, k)); end
            @(negedge clk);
        end
        checks++; if (replay_active !== 1'b0 || tx_valid !== 1'b0 || tlp_ready !== 1'b1) begin
            errors++; $display("FAIL nak_done got active %b valid %b ready %b exp 0/0/1", replay_active, tx_valid, tlp_ready); end
    endtask

    // T4: timer expiry resends seq 0 sixteen cycles after it first went out; a stalled
    // handshake defers the rewind until the link takes the current TLP.
    task automatic test_timeout();
        int gap;
        do_reset();
        tlp_valid = 1'b1; tlp_data = 32'hE000_0000;
        @(negedge clk);
        tlp_valid = 1'b0;
        checks++; if (tx_valid !== 1'b1 || tx_seq !== 12'd0) begin
            errors++; $display("FAIL tmo_first got v%b seq %0d exp v1 seq 0", tx_valid, tx_seq); end
        gap = -1;
        for (int i = 1; i <= 20 && gap < 0; i++) begin
            @(negedge clk);
            if (tx_valid) gap = i;
        end
        checks++; if (gap !== 16 || tx_seq !== 12'd0 || tx_data !== 32'hE000_0000 || replay_active !== 1'b1) begin
            errors++; $display("FAIL tmo_resend got gap %0d seq %0d data %h active %b exp 16/0/e0000000/1",
                               gap, tx_seq, tx_data, replay_active); end
        @(negedge clk);
        checks++; if (replay_active !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_done got active %b valid %b exp 0/0", replay_active, tx_valid); end

        do_reset();
        tx_ready = 1'b0;
        tlp_valid = 1'b1; tlp_data = 32'hE100_0000;
        @(negedge clk);
        tlp_valid = 1'b0;
        repeat (25) @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_seq !== 12'd0 || tx_data !== 32'hE100_0000 || replay_active !== 1'b0) begin
            errors++; $display("FAIL tmo_stall got v%b seq %0d data %h active %b exp 1/0/e1000000/0",
                               tx_valid, tx_seq, tx_data, replay_active); end
        tx_ready = 1'b1;
        @(negedge clk);
        checks++; if (replay_active !== 1'b1 || tx_valid !== 1'b1 || tx_seq !== 12'd0) begin
            errors++; $display("FAIL tmo_rewind got active %b v%b seq %0d exp 1/1/0", replay_active, tx_valid, tx_seq); end
        @(negedge clk);
        checks++; if (replay_active !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_rewind_done got active %b valid %b exp 0/0", replay_active, tx_valid); end
    endtask

    // T5: four timeouts without progress pulse link_retrain once; ACK 0 ends the replays.
    task automatic test_retrain();
        int rises, pulses, pulse_at, busy;
        logic prev;
        do_reset();
        tlp_valid = 1'b1; tlp_data = 32'hF000_0000;
        @(negedge clk);
        tlp_valid = 1'b0;
        rises = 0; pulses = 0; pulse_at = 0; prev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (replay_active && !prev) rises++;
            if (link_retrain) begin pulses++; pulse_at = rises; end
            prev = replay_active;
            if (rises == 4 && !replay_active) break;
        end
        checks++; if (rises !== 4 || pulses !== 1 || pulse_at !== 4) begin
            errors++; $display("FAIL retrain_pulse got replays %0d pulses %0d at replay %0d exp 4/1/4", rises, pulses, pulse_at); end
        send_dllp(ACK, 12'd0);
        checks++; if (dllp_err !== 1'b0) begin
            errors++; $display("FAIL retrain_ack got err %b exp 0", dllp_err); end
        busy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (replay_active || link_retrain) busy++;
        end
        checks++; if (busy !== 0) begin
            errors++; $display("FAIL retrain_stop got %0d replay cycles exp 0", busy); end
    endtask

    // T6: out-of-window ACK and unknown type raise dllp_err without disturbing state;
    // reset in the middle of a replay restarts numbering at 0.
    task automatic test_errors_and_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tlp_valid = 1'b1; tlp_data = pat(32'h1000_0000, i);
            @(negedge clk);
        end
        tlp_valid = 1'b0;
        repeat (2) @(negedge clk);
        send_dllp(ACK, 12'd7);
        checks++; if (dllp_err !== 1'b1) begin
            errors++; $display("FAIL err_ack_window got err %b exp 1", dllp_err); end
        @(negedge clk);
        checks++; if (dllp_err !== 1'b0 || tx_valid !== 1'b0 || replay_active !== 1'b0 || tlp_ready !== 1'b1) begin
            errors++; $display("FAIL err_pulse_len got err %b v%b active %b ready %b exp 0/0/0/1",
                               dllp_err, tx_valid, replay_active, tlp_ready); end
        send_dllp(ACK, 12'd0);
        checks++; if (dllp_err !== 1'b0) begin
            errors++; $display("FAIL err_state_kept got err %b exp 0 on ACK 0", dllp_err); end
        send_dllp(ACK, 12'd0);
        checks++; if (dllp_err !== 1'b0) begin
            errors++; $display("FAIL err_duplicate got err %b exp 0", dllp_err); end
        send_dllp(8'h55, 12'd1);
        checks++; if (dllp_err !== 1'b1) begin
            errors++; $display("FAIL err_type got err %b exp 1", dllp_err); end
        tx_ready = 1'b0;
        send_dllp(NAK, 12'd0);
        @(negedge clk);
        checks++; if (replay_active !== 1'b1 || tx_valid !== 1'b1 || tx_seq !== 12'd1) begin
            errors++; $display("FAIL err_replay got active %b v%b seq %0d exp 1/1/1", replay_active, tx_valid, tx_seq); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (replay_active !== 1'b0 || tx_valid !== 1'b0 || tlp_ready !== 1'b0) begin
            errors++; $display("FAIL err_async_reset got active %b v%b ready %b exp 0/0/0", replay_active, tx_valid, tlp_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        tlp_valid = 1'b1; tlp_data = 32'h2222_0000;
        @(negedge clk);
        tlp_valid = 1'b0;
        checks++; if (tx_valid !== 1'b1 || tx_seq !== 12'd0 || tx_data !== 32'h2222_0000) begin
            errors++; $display("FAIL err_restart got v%b seq %0d data %h exp 1/0/22220000", tx_valid, tx_seq, tx_data); end
    endtask

    // Streaming one TLP per cycle with running ACKs across the 4095 -> 0 wrap.
    task automatic test_back_to_back();
        localparam int N = 4100;
        int accepted, sent;
        logic ack_pend, bad;
        logic [11:0] ack_seq;
        do_reset();
        accepted = 0; sent = 0; ack_pend = 1'b0; ack_seq = '0; bad = 1'b0;
        for (int cyc = 0; cyc < 6000 && sent < N && !bad; cyc++) begin
            dllp_valid = 1'b0;
            if (ack_pend) begin
                dllp = {ACK, 12'h000, ack_seq}; dllp_valid = 1'b1; ack_pend = 1'b0;
            end
            checks++; if (dllp_err !== 1'b0) begin
                errors++; bad = 1'b1; $display("FAIL b2b_err got err %b exp 0 after %0d sent", dllp_err, sent); end
            if (tx_valid && !bad) begin
                checks++; if (tx_seq !== 12'(sent) || tx_data !== pat(32'hC000_0000, sent)) begin
                    errors++; bad = 1'b1;
                    $display("FAIL b2b_seq got seq %0d data %h exp seq %0d data %h", tx_seq, tx_data, 12'(sent), pat(32'hC000_0000, sent));
                end
                ack_seq = tx_seq; ack_pend = 1'b1; sent++;
            end
            tlp_valid = (accepted < N);
            tlp_data  = pat(32'hC000_0000, accepted);
            if (tlp_valid && tlp_ready) accepted++;
            @(negedge clk);
        end
        tlp_valid = 1'b0; dllp_valid = 1'b0;
        checks++; if (sent !== N) begin
            errors++; $display("FAIL b2b_count got %0d sent exp %0d", sent, N); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_depth();
        test_nak();
        test_timeout();
        test_retrain();
        test_errors_and_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
